// File: rtl/fma_issue_arb.sv
// fma_issue_arb: round-robin issue arbiter and in-order result sequencer for
// the shared, fixed-latency FMA datapath. Credits cover ops in the pipe plus
// entries in the result FIFO, so a completing op always finds a free slot.
`timescale 1ns/1ps
module fma_issue_arb #(
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic [1:0]      r0_prec,
  input  logic            r0_ismul,
  input  logic [TAGW-1:0] r0_tag,
  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic [1:0]      r1_prec,
  input  logic            r1_ismul,
  input  logic [TAGW-1:0] r1_tag,
  output logic            dp_en,
  output logic            dp_sel,
  output logic [1:0]      dp_prec,
  output logic [1:0]      dp_mode,
  output logic            dp_ismul,
  input  logic [4:0]      dp_flags,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_src,
  output logic [TAGW-1:0] rsp_tag,
  output logic [4:0]      rsp_flags,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]   cnt;
  logic            ptr;
  logic            can_issue;
  logic            gnt0;
  logic            gnt1;
  logic            issue;
  logic            pop;
  logic            wr_en;
  logic [1:0]      raw_prec;

  logic [LAT:1]    pipe_v;
  logic [LAT:1]    pipe_src;
  logic [TAGW-1:0] pipe_tag [1:LAT];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_src   [DEPTH];
  logic [TAGW-1:0] fifo_tag   [DEPTH];
  logic [4:0]      fifo_flags [DEPTH];

  assign can_issue = (cnt < CW'(DEPTH));
  assign issue     = gnt0 | gnt1;
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign wr_en     = pipe_v[LAT];
  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign busy      = (cnt != '0);
  assign rsp_src   = rsp_valid & fifo_src[rd_ptr];
  assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr] : '0;
  assign rsp_flags = rsp_valid ? fifo_flags[rd_ptr] : '0;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && can_issue) begin
      if (r0_valid && (!r1_valid || !ptr)) gnt0 = 1'b1;
      else if (r1_valid)                   gnt1 = 1'b1;
    end
  end

  // Datapath control is driven only in a grant cycle, zero otherwise.
  always_comb begin
    dp_en    = 1'b0;
    dp_sel   = 1'b0;
    dp_ismul = 1'b0;
    raw_prec = 2'b00;
    dp_prec  = 2'b00;
    if (gnt0) begin
      dp_en    = 1'b1;
      raw_prec = r0_prec;
      dp_ismul = r0_ismul;
    end else if (gnt1) begin
      dp_en    = 1'b1;
      dp_sel   = 1'b1;
      raw_prec = r1_prec;
      dp_ismul = r1_ismul;
    end
    if (issue) dp_prec = (raw_prec == 2'b00) ? 2'b11 : raw_prec;
    dp_mode = dp_prec;
  end

  // Credit counter and priority pointer; simultaneous issue and pop cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ptr <= 1'b0;
    end else begin
      if (issue && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !issue) cnt <= cnt - CW'(1);
      if (gnt0)      ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
    end
  end

  // Valid bits of the tracking pipe; cleared on reset to drop in-flight ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[1] <= issue;
      for (int i = 2; i <= LAT; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Source/tag payload of the tracking pipe, qualified by pipe_v.
  always_ff @(posedge clk) begin
    pipe_src[1] <= gnt1;
    pipe_tag[1] <= gnt1 ? r1_tag : r0_tag;
    for (int i = 2; i <= LAT; i++) begin
      pipe_src[i] <= pipe_src[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  // Result storage: capture the completing op together with its flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_src[wr_ptr]   <= pipe_src[LAT];
      fifo_tag[wr_ptr]   <= pipe_tag[LAT];
      fifo_flags[wr_ptr] <= dp_flags;
    end
  end

  // FIFO pointers and occupancy; write and pop in one cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (pop)   rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      if (wr_en && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !wr_en) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fma_issue_arb.sv
// tb_fma_issue_arb: table-driven grant/datapath vectors plus hand sequences
// for backpressure, credit boundary and mid-flight reset; responses are
// checked against a scoreboard queue filled at issue time.
`timescale 1ns/1ps
module tb_fma_issue_arb;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            r0_valid = 1'b0;
  logic            r0_ready;
  logic [1:0]      r0_prec = 2'b00;
  logic            r0_ismul = 1'b0;
  logic [TAGW-1:0] r0_tag = '0;
  logic            r1_valid = 1'b0;
  logic            r1_ready;
  logic [1:0]      r1_prec = 2'b00;
  logic            r1_ismul = 1'b0;
  logic [TAGW-1:0] r1_tag = '0;
  logic            dp_en;
  logic            dp_sel;
  logic [1:0]      dp_prec;
  logic [1:0]      dp_mode;
  logic            dp_ismul;
  logic [4:0]      dp_flags = 5'd0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_src;
  logic [TAGW-1:0] rsp_tag;
  logic [4:0]      rsp_flags;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         r0v;
    logic [1:0] r0p;
    bit         r0m;
    logic [3:0] r0t;
    bit         r1v;
    logic [1:0] r1p;
    bit         r1m;
    logic [3:0] r1t;
    bit         e0;
    bit         e1;
    bit         een;
    bit         esel;
    logic [1:0] eprec;
    bit         eism;
    bit         cb;
    bit         eb;
  } vec_t;

  typedef struct {
    bit         src;
    logic [3:0] tag;
    logic [4:0] flags;
    int         cyc;
    bit         strict;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  fma_issue_arb #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_prec(r0_prec),
    .r0_ismul(r0_ismul), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_prec(r1_prec),
    .r1_ismul(r1_ismul), .r1_tag(r1_tag),
    .dp_en(dp_en), .dp_sel(dp_sel), .dp_prec(dp_prec), .dp_mode(dp_mode),
    .dp_ismul(dp_ismul), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flag_of(input int c);
    logic [31:0] x;
    x = c * 13 + 7;
    return x[4:0];
  endfunction

  function automatic void compare(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic vec_t idle_v();
    return '{0, 2'b00, 0, 4'd0, 0, 2'b00, 0, 4'd0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
  endfunction

  function automatic vec_t r0_only(input logic [3:0] tag, input bit g, input bit cb, input bit eb);
    return '{1, 2'b10, 0, tag, 0, 2'b00, 0, 4'd0,
             g, 0, g, 0, (g ? 2'b10 : 2'b00), 0, cb, eb};
  endfunction

  // Cycle counter and a per-cycle flag pattern the bench can predict.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1 dp_flags = flag_of(cyc);
  end

  // Response scoreboard: every accepted entry must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_unexpected: got tag %0d src %0d with no op outstanding", rsp_tag, rsp_src);
      end else begin
        e = sb.pop_front();
        compare("rsp_src", rsp_src, e.src);
        compare("rsp_tag", rsp_tag, e.tag);
        compare("rsp_flags", rsp_flags, e.flags);
        if (e.strict) compare("rsp_latency", cyc, e.cyc);
        else if (cyc < e.cyc) compare("rsp_too_early", cyc, e.cyc);
      end
    end
  end

  // Result FIFO must never be written while full.
  always @(negedge clk) begin
    if (!rst && dut.wr_en && (dut.fifo_cnt == DEPTH)) begin
      checks++;
      errors++;
      $display("[TB] FAIL fifo_overflow: write with %0d entries stored, limit %0d", dut.fifo_cnt, DEPTH);
    end
  end

  task automatic checkOutput(input vec_t v);
    compare("r0_ready", r0_ready, v.e0);
    compare("r1_ready", r1_ready, v.e1);
    compare("dp_en", dp_en, v.een);
    compare("dp_sel", dp_sel, v.esel);
    compare("dp_prec", dp_prec, v.eprec);
    compare("dp_mode", dp_mode, v.eprec);
    compare("dp_ismul", dp_ismul, v.eism);
    if (v.cb) compare("busy", busy, v.eb);
  endtask

  // Called at posedge+1: drive one cycle, record expected responses, check mid-cycle.
  task automatic applyStimulus(input vec_t v, input logic rr, input bit strict);
    r0_valid = v.r0v; r0_prec = v.r0p; r0_ismul = v.r0m; r0_tag = v.r0t;
    r1_valid = v.r1v; r1_prec = v.r1p; r1_ismul = v.r1m; r1_tag = v.r1t;
    rsp_ready = rr;
    if (v.e0) sb.push_back('{1'b0, v.r0t, flag_of(cyc + LAT), cyc + LAT + 1, strict});
    if (v.e1) sb.push_back('{1'b1, v.r1t, flag_of(cyc + LAT), cyc + LAT + 1, strict});
    @(negedge clk);
    checkOutput(v);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    compare("drain_left", sb.size(), 0);
    compare("drain_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{1, 2'b10, 1, 4'd3,  0, 2'b00, 0, 4'd0,  1, 0, 1, 0, 2'b10, 1, 1, 0};
    tbl[1] = '{1, 2'b11, 0, 4'd5,  1, 2'b01, 1, 4'd6,  0, 1, 1, 1, 2'b01, 1, 1, 1};
    tbl[2] = '{1, 2'b01, 1, 4'd7,  1, 2'b00, 0, 4'd8,  1, 0, 1, 0, 2'b01, 1, 0, 0};
    tbl[3] = '{1, 2'b10, 0, 4'd9,  1, 2'b00, 1, 4'd10, 0, 1, 1, 1, 2'b11, 1, 0, 0};
    tbl[4] = idle_v();
    tbl[5] = '{1, 2'b10, 0, 4'd11, 1, 2'b11, 1, 4'd0,  1, 0, 1, 0, 2'b10, 0, 0, 0};
    tbl[6] = '{1, 2'b00, 1, 4'd12, 0, 2'b00, 0, 4'd0,  1, 0, 1, 0, 2'b11, 1, 0, 0};
    tbl[7] = '{1, 2'b01, 0, 4'd14, 1, 2'b11, 1, 4'd13, 0, 1, 1, 1, 2'b11, 1, 0, 0};
    tbl[8] = '{1, 2'b10, 0, 4'd1,  1, 2'b10, 1, 4'd2,  1, 0, 1, 0, 2'b10, 0, 0, 0};
    tbl[9] = '{1, 2'b11, 1, 4'd4,  1, 2'b01, 0, 4'd15, 0, 1, 1, 1, 2'b01, 0, 0, 0};

    // Reset: no grant while rst is high even with both requesters valid.
    rst = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    compare("rst_r0_ready", r0_ready, 0);
    compare("rst_r1_ready", r1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    compare("post_rst_dp_en", dp_en, 0);
    compare("post_rst_rsp_valid", rsp_valid, 0);
    compare("post_rst_rsp_src", rsp_src, 0);
    compare("post_rst_rsp_tag", rsp_tag, 0);
    compare("post_rst_rsp_flags", rsp_flags, 0);
    compare("post_rst_busy", busy, 0);
    compare("post_rst_ready", {r0_ready, r1_ready}, 0);
    @(posedge clk); #1;

    // Grant pattern, precision mapping and exact issue-to-response latency.
    for (int i = 0; i < 10; i++) applyStimulus(tbl[i], 1'b1, 1'b1);
    waitDrain(40);

    // Backpressure: credits stop issue at DEPTH; one pop frees one issue next cycle.
    for (int i = 0; i < 12; i++) applyStimulus(r0_only(4'(i), (i < DEPTH), 0, 0), 1'b0, 1'b0);
    applyStimulus(r0_only(4'd12, 0, 1, 1), 1'b1, 1'b0);
    applyStimulus(r0_only(4'd13, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(r0_only(4'd14, 0, 1, 1), 1'b0, 1'b0);
    applyStimulus(r0_only(4'd15, 0, 0, 0), 1'b0, 1'b0);
    waitDrain(60);

    // Issue and pop together at DEPTH-1 leave the credit count unchanged.
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(r0_only(4'(i + 3), 1, 0, 0), 1'b0, 1'b0);
    for (int i = 0; i < LAT + 2; i++) applyStimulus(idle_v(), 1'b0, 1'b0);
    applyStimulus(r0_only(4'd10, 1, 1, 1), 1'b1, 1'b0);
    applyStimulus(r0_only(4'd11, 1, 0, 0), 1'b0, 1'b0);
    applyStimulus(r0_only(4'd12, 0, 1, 1), 1'b0, 1'b0);
    waitDrain(60);

    // Reset with three ops in flight: they vanish and the pointer returns to r0.
    for (int i = 0; i < 3; i++) applyStimulus(r0_only(4'(i + 7), 1, 0, 0), 1'b1, 1'b1);
    rst = 1'b1;
    applyStimulus('{1, 2'b10, 0, 4'd5, 1, 2'b01, 1, 4'd6, 0, 0, 0, 0, 2'b00, 0, 0, 0}, 1'b1, 1'b1);
    rst = 1'b0;
    sb.delete();
    applyStimulus('{1, 2'b10, 1, 4'd5, 1, 2'b01, 0, 4'd6, 1, 0, 1, 0, 2'b10, 1, 1, 0}, 1'b1, 1'b1);
    applyStimulus(idle_v(), 1'b1, 1'b1);
    compare("rst_rsp_valid", rsp_valid, 0);
    waitDrain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
